convolution: RTL and testbench

Four-tap linear convolution engine for the CNN accelerator datapath. Each accepted sample set pairs one 4-element input vector x with one 4-tap kernel h and produces the full 7-point linear convolution y = x * h. The block sits between the operand buffers and the accumulator/writeback stage. It is a two-stage pipeline accepting one operand set per clock, with no backpressure.

---
 rtl/conv_pkg.sv | 15 +
 rtl/convolution_if.sv | 23 ++
 rtl/conv_mul_array.sv | 31 +++
 rtl/convolution.sv | 69 ++++++
 tb/tb_convolution.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths and element types for the convolution engine
package conv_pkg;

  localparam int DATA_W = 6;
  localparam int N_TAPS = 4;
  localparam int N_OUT  = 7;
  localparam int N_PROD = N_TAPS * N_TAPS;
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = 2 * DATA_W + 2;

  typedef logic [DATA_W-1:0] elem_t;
  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [SUM_W-1:0]  sum_t;

endpackage

// File: rtl/convolution_if.sv
// rtl/convolution_if.sv - operand/result bundle for the convolution engine
interface convolution_if;
  import conv_pkg::*;

  logic  in_valid;
  elem_t x0, x1, x2, x3;
  elem_t h0, h1, h2, h3;
  logic  out_valid;
  elem_t y0, y1, y2, y3, y4, y5, y6;

  // Operand producer / result consumer side
  modport master (
    output in_valid, x0, x1, x2, x3, h0, h1, h2, h3,
    input  out_valid, y0, y1, y2, y3, y4, y5, y6
  );

  // Convolution engine side
  modport slave (
    input  in_valid, x0, x1, x2, x3, h0, h1, h2, h3,
    output out_valid, y0, y1, y2, y3, y4, y5, y6
  );

endinterface

// File: rtl/conv_mul_array.sv
// rtl/conv_mul_array.sv - 4x4 unsigned multiplier array with stage-1 registers
module conv_mul_array
  import conv_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  elem_t [N_TAPS-1:0]     x,
  input  elem_t [N_TAPS-1:0]     h,
  output prod_t [N_PROD-1:0]     prod,
  output logic                   valid
);

  // Register every x[i]*h[j] at index i*N_TAPS+j; products hold while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < N_TAPS; i++) begin
          for (int j = 0; j < N_TAPS; j++) begin
            prod[i*N_TAPS+j] <= prod_t'(x[i]) * prod_t'(h[j]);
          end
        end
      end
    end
  end

endmodule

// File: rtl/convolution.sv
// rtl/convolution.sv - two-stage four-tap linear convolution engine
module convolution
  import conv_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  convolution_if.slave  bus
);

  elem_t [N_TAPS-1:0] x_vec;
  elem_t [N_TAPS-1:0] h_vec;
  prod_t [N_PROD-1:0] prod;
  logic               s1_valid;
  sum_t  [N_OUT-1:0]  sum;
  elem_t [N_OUT-1:0]  y_q;
  logic               out_valid_q;

  assign x_vec = {bus.x3, bus.x2, bus.x1, bus.x0};
  assign h_vec = {bus.h3, bus.h2, bus.h1, bus.h0};

  conv_mul_array u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.in_valid),
    .x        (x_vec),
    .h        (h_vec),
    .prod     (prod),
    .valid    (s1_valid)
  );

  // Anti-diagonal adder trees: y[n] collects every product with i+j == n
  always_comb begin
    for (int n = 0; n < N_OUT; n++) begin
      sum[n] = '0;
      for (int i = 0; i < N_TAPS; i++) begin
        for (int j = 0; j < N_TAPS; j++) begin
          if (i + j == n) begin
            sum[n] = sum[n] + sum_t'(prod[i*N_TAPS+j]);
          end
        end
      end
    end
  end

  // Output stage: keep the low DATA_W bits of each sum; results hold while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        for (int n = 0; n < N_OUT; n++) begin
          y_q[n] <= sum[n][DATA_W-1:0];
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.y0 = y_q[0];
  assign bus.y1 = y_q[1];
  assign bus.y2 = y_q[2];
  assign bus.y3 = y_q[3];
  assign bus.y4 = y_q[4];
  assign bus.y5 = y_q[5];
  assign bus.y6 = y_q[6];

endmodule

// File: tb/tb_convolution.sv
// tb/tb_convolution.sv - directed self-checking bench for the convolution engine
module tb_convolution;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  convolution_if bus ();

  convolution dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int a0, input int a1, input int a2, input int a3,
                       input int b0, input int b1, input int b2, input int b3);
    bus.in_valid = v;
    bus.x0 = 6'(a0); bus.x1 = 6'(a1); bus.x2 = 6'(a2); bus.x3 = 6'(a3);
    bus.h0 = 6'(b0); bus.h1 = 6'(b1); bus.h2 = 6'(b2); bus.h3 = 6'(b3);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_y(input string tag, input int ov,
                         input int e0, input int e1, input int e2, input int e3,
                         input int e4, input int e5, input int e6);
    check({tag, ".out_valid"}, int'(bus.out_valid), ov);
    check({tag, ".y0"}, int'(bus.y0), e0);
    check({tag, ".y1"}, int'(bus.y1), e1);
    check({tag, ".y2"}, int'(bus.y2), e2);
    check({tag, ".y3"}, int'(bus.y3), e3);
    check({tag, ".y4"}, int'(bus.y4), e4);
    check({tag, ".y5"}, int'(bus.y5), e5);
    check({tag, ".y6"}, int'(bus.y6), e6);
  endtask

  // Streaming expectations, one row per operand set in issue order
  int exp_stream [4][7] = '{
    '{1, 2, 3, 4, 3, 2, 1},
    '{2, 4, 6, 8, 0, 0, 0},
    '{0, 0, 0, 1, 2, 3, 4},
    '{30, 30, 30, 40, 10, 10, 10}
  };

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check_y("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Basic: result visible at the second negedge after driving
    @(negedge clk);
    drive(1'b1, 1, 2, 3, 4, 1, 2, 2, 1);
    @(negedge clk);
    idle();
    check("basic.early_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    check_y("basic", 1, 1, 4, 9, 15, 16, 11, 4);
    // Hold: single-cycle pulse, values retained
    @(negedge clk);
    check_y("hold", 0, 1, 4, 9, 15, 16, 11, 4);
    @(negedge clk);
    check_y("hold2", 0, 1, 4, 9, 15, 16, 11, 4);

    // Wrap-around
    drive(1'b1, 63, 63, 63, 63, 63, 63, 63, 63);
    @(negedge clk);
    idle();
    @(negedge clk);
    check_y("wrap", 1, 1, 2, 3, 4, 3, 2, 1);

    // Impulses
    drive(1'b1, 5, 0, 0, 0, 7, 3, 1, 2);
    @(negedge clk);
    drive(1'b1, 9, 8, 7, 6, 1, 0, 0, 0);
    @(negedge clk);
    idle();
    check_y("imp_x", 1, 35, 15, 5, 10, 0, 0, 0);
    @(negedge clk);
    check_y("imp_h", 1, 9, 8, 7, 6, 0, 0, 0);
    @(negedge clk);
    check("imp.drop", int'(bus.out_valid), 0);

    // Streaming: four sets back-to-back, results checked two negedges later
    for (int c = 0; c < 6; c++) begin
      if (c >= 2) begin
        check_y($sformatf("stream%0d", c - 2), 1,
                exp_stream[c-2][0], exp_stream[c-2][1], exp_stream[c-2][2],
                exp_stream[c-2][3], exp_stream[c-2][4], exp_stream[c-2][5],
                exp_stream[c-2][6]);
      end
      case (c)
        0: drive(1'b1, 1, 1, 1, 1, 1, 1, 1, 1);
        1: drive(1'b1, 2, 0, 0, 0, 1, 2, 3, 4);
        2: drive(1'b1, 0, 0, 0, 1, 1, 2, 3, 4);
        3: drive(1'b1, 10, 10, 10, 10, 3, 0, 0, 1);
        default: idle();
      endcase
      @(negedge clk);
    end
    check("stream.drop", int'(bus.out_valid), 0);

    // Reset mid-flight: set sampled, reset one cycle later before stage 2
    drive(1'b1, 1, 2, 3, 4, 1, 2, 2, 1);
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    check_y("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst_mid.no_pulse%0d", c), int'(bus.out_valid), 0);
    end
    check("rst_mid.y3", int'(bus.y3), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
